// File: rtl/cnn_frame_scheduler.sv
// cnn_frame_scheduler: runs NUM_FRAMES back-to-back inference frames through
// the accelerator (reset pulse, gap-free byte stream, wait result, report).
// Ports: clk/rst_n (sync, active low), start/abort control, busy/done status,
// mem_addr/mem_rdata frame ROM (1-cycle latency), acc_* accelerator side,
// res_* per-frame result (res_valid pulses, other fields hold).
module cnn_frame_scheduler #(
  parameter int FRAME_LEN  = 884,
  parameter int NUM_FRAMES = 6,
  parameter int ADDR_W     = 13,
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 300000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              acc_rst_n,
  output logic [7:0]        acc_data_in,
  output logic              acc_valid_in,
  input  logic [31:0]       acc_data_out,
  input  logic              acc_valid_out,
  input  logic              acc_warning,
  output logic              res_valid,
  output logic [2:0]        res_frame,
  output logic [31:0]       res_data,
  output logic              res_warning,
  output logic              res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_STREAM, S_WAIT, S_REPORT, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       cnt_q, cnt_d;
  logic [2:0]        frame_q, frame_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d;
  logic [31:0]       abcnt_q, abcnt_d;
  logic              arst_q, arst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic [2:0]        rfrm_q, rfrm_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              rwrn_q, rwrn_d;
  logic              rto_q, rto_d;

  logic abort_go;
  logic last_frame;

  assign abort_go   = abort && (state_q != S_IDLE);
  assign last_frame = (frame_q == 3'(NUM_FRAMES - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_RST;
      end
      S_RST: begin
        if (cnt_q == 32'(RST_CYCLES - 1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        // two extra cycles drain the ROM/output pipeline
        if (cnt_q == 32'(FRAME_LEN + 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_valid_out || cnt_q == 32'(TIMEOUT - 1))
          state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = last_frame ? S_DONE : S_RST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_go) state_d = S_IDLE;
  end

  // outputs / datapath next values
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;

    frame_d = frame_q;
    base_d  = base_q;
    if (state_q == S_IDLE && state_d == S_RST) begin
      frame_d = '0;
      base_d  = '0;
    end else if (state_q == S_REPORT && state_d == S_RST) begin
      frame_d = frame_q + 3'd1;
      base_d  = base_q + ADDR_W'(FRAME_LEN);
    end

    addr_d = addr_q;
    if (state_q == S_RST && state_d == S_STREAM) begin
      addr_d = base_q;
    end else if (state_q == S_STREAM
                 && cnt_q < 32'(FRAME_LEN - 1)) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    // rd_q marks the cycle mem_rdata holds a byte of this frame
    rd_d   = (state_q == S_STREAM) && (cnt_q < 32'(FRAME_LEN))
             && !abort_go;
    vld_d  = rd_q && !abort_go;
    data_d = rd_q ? mem_rdata : data_q;

    abcnt_d = '0;
    if (abort_go) abcnt_d = 32'(RST_CYCLES);
    else if (abcnt_q != '0) abcnt_d = abcnt_q - 32'd1;

    arst_d = !((state_d == S_RST) || (abcnt_d != '0));
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    rv_d   = (state_d == S_REPORT);

    rfrm_d = rfrm_q;
    rdat_d = rdat_q;
    rwrn_d = rwrn_q;
    rto_d  = rto_q;
    if (state_q == S_WAIT && state_d == S_REPORT) begin
      rfrm_d = frame_q;
      if (acc_valid_out) begin
        rdat_d = acc_data_out;
        rwrn_d = acc_warning;
        rto_d  = 1'b0;
      end else begin
        rdat_d = '0;
        rwrn_d = 1'b0;
        rto_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      frame_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      abcnt_q <= '0;
      arst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      rfrm_q  <= '0;
      rdat_q  <= '0;
      rwrn_q  <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      abcnt_q <= abcnt_d;
      arst_q  <= arst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rfrm_q  <= rfrm_d;
      rdat_q  <= rdat_d;
      rwrn_q  <= rwrn_d;
      rto_q   <= rto_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_addr     = addr_q;
  assign acc_rst_n    = arst_q;
  assign acc_data_in  = data_q;
  assign acc_valid_in = vld_q;
  assign res_valid    = rv_q;
  assign res_frame    = rfrm_q;
  assign res_data     = rdat_q;
  assign res_warning  = rwrn_q;
  assign res_timeout  = rto_q;

endmodule
